// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: issues one request per load/store,
// stalls the front of the pipeline until the access completes, and drives the MEM/WB register.
module mem_access_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        RegWrite_i,
  input  logic        MemWrite_i,
  input  logic        MemRead_i,
  input  logic        Mem2Reg_i,
  input  logic [31:0] ALU_data_i,
  input  logic [31:0] writeData_i,
  input  logic [4:0]  RDaddr_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        stall_o,
  output logic        RegWrite_o,
  output logic        Mem2Reg_o,
  output logic [31:0] ReadData_o,
  output logic [31:0] ALU_data_o,
  output logic [4:0]  RDaddr_o,
  output logic        misalign_o,
  output logic        err_o
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t      state;
  logic [7:0]  timeout_cnt;
  logic        abort;
  logic        we_q;
  logic [31:0] rdata_q;

  logic mem_op;
  logic aligned;
  logic access_start;

  assign mem_op       = MemRead_i | MemWrite_i;
  assign aligned      = (ALU_data_i[1:0] == 2'b00);
  assign access_start = (state == IDLE) && mem_op && aligned;

  // NOTE: stall_o must be combinational so the pipeline freezes in the same
  // cycle the access is first seen; a registered stall would lose one instruction.
  assign stall_o   = access_start || (state == REQ);
  assign dmem_we_o = dmem_req_o & we_q;

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      timeout_cnt  <= 8'd0;
      abort        <= 1'b0;
      we_q         <= 1'b0;
      rdata_q      <= 32'd0;
      dmem_req_o   <= 1'b0;
      dmem_addr_o  <= 32'd0;
      dmem_wdata_o <= 32'd0;
      RegWrite_o   <= 1'b0;
      Mem2Reg_o    <= 1'b0;
      ReadData_o   <= 32'd0;
      ALU_data_o   <= 32'd0;
      RDaddr_o     <= 5'd0;
      misalign_o   <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      misalign_o <= 1'b0;
      err_o      <= 1'b0;
      case (state)
        IDLE: begin
          if (access_start) begin
            // Bubble into MEM/WB while the instruction waits in EX/MEM.
            RegWrite_o   <= 1'b0;
            Mem2Reg_o    <= 1'b0;
            dmem_req_o   <= 1'b1;
            dmem_addr_o  <= ALU_data_i;
            dmem_wdata_o <= writeData_i;
            we_q         <= MemWrite_i;
            timeout_cnt  <= 8'd0;
            abort        <= 1'b0;
            state        <= REQ;
          end else begin
            // A misaligned access retires without writing back.
            RegWrite_o <= RegWrite_i & ~mem_op;
            Mem2Reg_o  <= Mem2Reg_i;
            ALU_data_o <= ALU_data_i;
            RDaddr_o   <= RDaddr_i;
            ReadData_o <= 32'd0;
            misalign_o <= mem_op;
          end
        end
        REQ: begin
          RegWrite_o <= 1'b0;
          Mem2Reg_o  <= 1'b0;
          if (dmem_ack_i) begin
            rdata_q    <= we_q ? 32'd0 : dmem_rdata_i;
            dmem_req_o <= 1'b0;
            state      <= RESP;
          end else begin
            timeout_cnt <= timeout_cnt + 8'd1;
            // Count 254 -> 255 ends the 255th unacknowledged request cycle.
            if (timeout_cnt == 8'd254) begin
              abort      <= 1'b1;
              rdata_q    <= 32'd0;
              dmem_req_o <= 1'b0;
              state      <= RESP;
            end
          end
        end
        RESP: begin
          RegWrite_o <= RegWrite_i & ~abort;
          Mem2Reg_o  <= Mem2Reg_i;
          ALU_data_o <= ALU_data_i;
          RDaddr_o   <= RDaddr_i;
          ReadData_o <= abort ? 32'd0 : rdata_q;
          err_o      <= abort;
          abort      <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: instruction-level expectations checked against
// every output on each falling edge, plus literal checks on key results.
module tb_mem_access_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        RegWrite_i = 1'b0, MemWrite_i = 1'b0, MemRead_i = 1'b0, Mem2Reg_i = 1'b0;
  logic [31:0] ALU_data_i = '0, writeData_i = '0;
  logic [4:0]  RDaddr_i = '0;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic        dmem_ack_i = 1'b0;
  logic [31:0] dmem_rdata_i = '0;
  logic        stall_o;
  logic        RegWrite_o, Mem2Reg_o;
  logic [31:0] ReadData_o, ALU_data_o;
  logic [4:0]  RDaddr_o;
  logic        misalign_o, err_o;

  mem_access_unit dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .RegWrite_i(RegWrite_i), .MemWrite_i(MemWrite_i), .MemRead_i(MemRead_i), .Mem2Reg_i(Mem2Reg_i),
    .ALU_data_i(ALU_data_i), .writeData_i(writeData_i), .RDaddr_i(RDaddr_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i), .stall_o(stall_o),
    .RegWrite_o(RegWrite_o), .Mem2Reg_o(Mem2Reg_o), .ReadData_o(ReadData_o),
    .ALU_data_o(ALU_data_o), .RDaddr_o(RDaddr_o), .misalign_o(misalign_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  // Expected output values for the current cycle.
  logic        e_stall = 0, e_req = 0, e_we = 0, e_rw = 0, e_m2r = 0, e_mis = 0, e_err = 0;
  logic [31:0] e_addr = 0, e_wdata = 0, e_read = 0, e_alu = 0;
  logic [4:0]  e_rd = 0;

  int stall_cnt = 0, req_cnt = 0, we_cnt = 0, mis_cnt = 0, err_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    if (check_en) begin
      check("stall",     32'(stall_o),    32'(e_stall));
      check("dmem_req",  32'(dmem_req_o), 32'(e_req));
      check("dmem_we",   32'(dmem_we_o),  32'(e_we));
      check("dmem_addr", dmem_addr_o,     e_addr);
      check("dmem_wdata", dmem_wdata_o,   e_wdata);
      check("RegWrite",  32'(RegWrite_o), 32'(e_rw));
      check("Mem2Reg",   32'(Mem2Reg_o),  32'(e_m2r));
      check("ReadData",  ReadData_o,      e_read);
      check("ALU_data",  ALU_data_o,      e_alu);
      check("RDaddr",    32'(RDaddr_o),   32'(e_rd));
      check("misalign",  32'(misalign_o), 32'(e_mis));
      check("err",       32'(err_o),      32'(e_err));
      if (stall_o)    stall_cnt++;
      if (dmem_req_o) req_cnt++;
      if (dmem_we_o)  we_cnt++;
      if (misalign_o) mis_cnt++;
      if (err_o)      err_cnt++;
    end
  end

  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_counts();
    stall_cnt = 0; req_cnt = 0; we_cnt = 0; mis_cnt = 0; err_cnt = 0;
  endtask

  task automatic clear_expect();
    e_stall = 0; e_req = 0; e_we = 0; e_rw = 0; e_m2r = 0; e_mis = 0; e_err = 0;
    e_addr = 0; e_wdata = 0; e_read = 0; e_alu = 0; e_rd = 0;
  endtask

  task automatic drive(input logic rw, input logic mw, input logic mr, input logic m2r,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd);
    RegWrite_i = rw; MemWrite_i = mw; MemRead_i = mr; Mem2Reg_i = m2r;
    ALU_data_i = alu; writeData_i = wd; RDaddr_i = rd;
  endtask

  // Non-memory instruction; a stray ack is presented and must be ignored.
  task automatic op_alu(input logic rw, input logic m2r, input logic [31:0] alu, input logic [4:0] rd);
    drive(rw, 1'b0, 1'b0, m2r, alu, 32'h0, rd);
    dmem_ack_i = 1'b1; dmem_rdata_i = $urandom;
    e_stall = 0;
    cycle();
    dmem_ack_i = 1'b0;
    e_rw = rw; e_m2r = m2r; e_alu = alu; e_rd = rd; e_read = 0; e_mis = 0; e_err = 0;
  endtask

  // Memory instruction; ack_at is the 1-based request cycle that acks (0 = never).
  task automatic op_mem(input logic mr, input logic mw, input logic rw, input logic m2r,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                        input int ack_at, input logic [31:0] rdata);
    logic [31:0] captured;
    bit          timeout;
    drive(rw, mw, mr, m2r, addr, wd, rd);
    dmem_ack_i = 1'b0;
    if (addr[1:0] != 2'b00) begin
      e_stall = 0;
      cycle();
      e_rw = 0; e_m2r = m2r; e_alu = addr; e_rd = rd; e_read = 0; e_mis = 1; e_err = 0;
      return;
    end
    e_stall = 1;
    cycle();
    e_rw = 0; e_m2r = 0; e_mis = 0; e_err = 0;
    e_req = 1; e_we = mw; e_addr = addr; e_wdata = wd;
    timeout = 1'b1;
    for (int k = 1; k <= 255; k++) begin
      dmem_ack_i   = (k == ack_at);
      dmem_rdata_i = (k == ack_at) ? rdata : $urandom;
      cycle();
      if (k == ack_at) begin
        timeout = 1'b0;
        break;
      end
    end
    captured = (timeout || mw) ? 32'h0 : rdata;
    e_req = 0; e_we = 0; e_stall = 0;
    dmem_ack_i = 1'b1; dmem_rdata_i = $urandom;
    cycle();
    dmem_ack_i = 1'b0;
    e_rw = rw & ~timeout; e_m2r = m2r; e_alu = addr; e_rd = rd;
    e_read = captured; e_err = timeout; e_mis = 0;
  endtask

  // Load whose request is abandoned by reset in its second request cycle.
  task automatic op_reset_in_req(input logic [31:0] addr);
    drive(1'b1, 1'b0, 1'b1, 1'b1, addr, 32'h0, 5'd3);
    dmem_ack_i = 1'b0;
    e_stall = 1;
    cycle();
    e_rw = 0; e_m2r = 0; e_mis = 0; e_err = 0;
    e_req = 1; e_we = 0; e_addr = addr; e_wdata = 0;
    cycle();
    rst_i = 1'b1;
    cycle();
    rst_i = 1'b0;
    clear_expect();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
  endtask

  initial begin
    clear_expect();
    repeat (2) cycle();
    rst_i = 1'b0;
    check_en = 1'b1;
    check("reset_req",      32'(dmem_req_o), 32'd0);
    check("reset_RegWrite", 32'(RegWrite_o), 32'd0);
    check("reset_ALU_data", ALU_data_o,      32'd0);

    // Plain ALU op.
    clear_counts();
    op_alu(1'b1, 1'b0, 32'h0000_1234, 5'd5);
    check("alu_RegWrite", 32'(RegWrite_o), 32'd1);
    check("alu_ALU_data", ALU_data_o,      32'h0000_1234);
    check("alu_RDaddr",   32'(RDaddr_o),   32'd5);
    check("alu_stalls",   stall_cnt,       32'd0);

    // Load, acked in the third request cycle.
    clear_counts();
    op_mem(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h0, 5'd7, 3, 32'hDEAD_BEEF);
    check("load_ReadData", ReadData_o,     32'hDEAD_BEEF);
    check("load_Mem2Reg",  32'(Mem2Reg_o), 32'd1);
    check("load_stalls",   stall_cnt,      32'd4);

    // Store, acked in the first request cycle.
    clear_counts();
    op_mem(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0200, 32'hCAFE_F00D, 5'd0, 1, 32'h1357_9BDF);
    check("store_stalls",   stall_cnt,       32'd2);
    check("store_we_cycles", we_cnt,         32'd1);
    check("store_RegWrite", 32'(RegWrite_o), 32'd0);
    check("store_ReadData", ReadData_o,      32'd0);

    // Misaligned load.
    clear_counts();
    op_mem(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0102, 32'h0, 5'd9, 1, 32'h0);
    check("mis_pulse",    32'(misalign_o), 32'd1);
    check("mis_RegWrite", 32'(RegWrite_o), 32'd0);
    op_alu(1'b0, 1'b0, 32'h0000_0040, 5'd1);
    check("mis_pulse_len", mis_cnt,   32'd1);
    check("mis_no_req",    req_cnt,   32'd0);
    check("mis_no_stall",  stall_cnt, 32'd0);

    // Load that is never acknowledged.
    clear_counts();
    op_mem(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0300, 32'h0, 5'd10, 0, 32'h0);
    check("to_err",      32'(err_o),      32'd1);
    check("to_RegWrite", 32'(RegWrite_o), 32'd0);
    check("to_ReadData", ReadData_o,      32'd0);
    check("to_req_len",  req_cnt,         32'd255);
    op_alu(1'b1, 1'b0, 32'h0000_0044, 5'd2);
    check("to_err_len",  err_cnt,         32'd1);

    // Read and write both set: handled as a store.
    op_mem(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0400, 32'h1111_2222, 5'd11, 2, 32'h5555_5555);
    check("rw_ReadData", ReadData_o, 32'd0);

    // Reset in the middle of a request.
    clear_counts();
    op_reset_in_req(32'h0000_0500);
    #1;
    check("rst_req",      32'(dmem_req_o), 32'd0);
    check("rst_stall",    32'(stall_o),    32'd0);
    check("rst_err",      32'(err_o),      32'd0);
    check("rst_RegWrite", 32'(RegWrite_o), 32'd0);
    op_alu(1'b0, 1'b0, 32'h0, 5'd0);
    check("rst_no_err", err_cnt, 32'd0);
    op_mem(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0600, 32'h0, 5'd12, 1, 32'h0BAD_F00D);
    check("post_rst_ReadData", ReadData_o, 32'h0BAD_F00D);
    op_alu(1'b1, 1'b0, 32'h0000_00FF, 5'd31);

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
